// File: rtl/vend_select_fsm.sv
// vend_select_fsm
//   Turns debounced keypad events into a validated purchase request
//   (slot, quantity, stock check) and offers it downstream with valid/ready.
//   Rejected ok presses produce a one-cycle err_pulse.
// Ports
//   i_clk, i_rst_n          clock, asynchronous active-low reset
//   key_valid/val/ok/back   scanner level outputs
//   admin_en                forces IDLE and masks key events
//   slot_stock              3-bit stock per slot, slot n at [3n-1:3n-3]
//   sel_ready / sel_valid   handshake with the payment stage
//   sel_slot, sel_qty       current selection (0 = none)
//   err_pulse               rejected ok press
//   ui_state                0 IDLE, 1 SLOT, 2 QTY, 3 OFFER
module vend_select_fsm #(
    parameter int unsigned SETTLE_CYC  = 1500000,
    parameter int unsigned TIMEOUT_CYC = 500000000
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        key_valid,
    input  logic [2:0]  key_val,
    input  logic        key_ok,
    input  logic        key_back,
    input  logic        admin_en,
    input  logic [20:0] slot_stock,
    input  logic        sel_ready,
    output logic        sel_valid,
    output logic [2:0]  sel_slot,
    output logic [2:0]  sel_qty,
    output logic        err_pulse,
    output logic [1:0]  ui_state
);
    localparam int SW = $clog2(SETTLE_CYC + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [SW-1:0] SETTLE_MAX   = SW'(SETTLE_CYC);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SLOT  = 2'd1,
        ST_QTY   = 2'd2,
        ST_OFFER = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        EV_DIGIT = 2'd0,
        EV_OK    = 2'd1,
        EV_BACK  = 2'd2
    } ev_kind_e;

    typedef struct packed {
        logic       vld;
        ev_kind_e   kind;
        logic [2:0] digit;
    } key_ev_t;

    logic [SW-1:0] settle_cnt_q, settle_cnt_d;
    key_ev_t       ev_q, ev_d;
    state_e        state_q, state_d;
    logic [2:0]    slot_q, slot_d;
    logic [2:0]    qty_q, qty_d;
    logic          sel_valid_q, sel_valid_d;
    logic          err_q, err_d;
    logic [TW-1:0] idle_cnt_q, idle_cnt_d;

    // Stock of the currently selected slot; a zero slot lands on padding.
    logic [23:0] stock_ext;
    logic [4:0]  stock_base;
    logic [2:0]  cur_stock;
    assign stock_ext  = {slot_stock, 3'b000};
    assign stock_base = {2'b00, slot_q} * 5'd3;
    assign cur_stock  = stock_ext[stock_base +: 3];

    // Event qualifier: one event when the hold count reaches SETTLE_CYC,
    // then the counter parks until key_valid drops.
    always_comb begin
        settle_cnt_d = settle_cnt_q;
        ev_d         = '0;
        if (!key_valid) begin
            settle_cnt_d = '0;
        end else if (settle_cnt_q != SETTLE_MAX) begin
            settle_cnt_d = settle_cnt_q + 1'b1;
            if (settle_cnt_q == SETTLE_MAX - 1'b1) begin
                ev_d.vld   = !admin_en;
                ev_d.digit = key_val;
                if (key_back)    ev_d.kind = EV_BACK;
                else if (key_ok) ev_d.kind = EV_OK;
                else             ev_d.kind = EV_DIGIT;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        slot_d      = slot_q;
        qty_d       = qty_q;
        sel_valid_d = sel_valid_q;
        err_d       = 1'b0;
        idle_cnt_d  = idle_cnt_q;
        if (admin_en) begin
            state_d     = ST_IDLE;
            slot_d      = '0;
            qty_d       = '0;
            sel_valid_d = 1'b0;
            idle_cnt_d  = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (ev_q.vld && ev_q.kind == EV_DIGIT && ev_q.digit != 3'd0) begin
                        slot_d  = ev_q.digit;
                        state_d = ST_SLOT;
                    end
                end
                ST_SLOT: begin
                    if (ev_q.vld) begin
                        case (ev_q.kind)
                            EV_DIGIT: if (ev_q.digit != 3'd0) slot_d = ev_q.digit;
                            EV_BACK: begin
                                slot_d  = '0;
                                state_d = ST_IDLE;
                            end
                            default: begin
                                if (cur_stock == 3'd0) begin
                                    err_d   = 1'b1;
                                    slot_d  = '0;
                                    state_d = ST_IDLE;
                                end else begin
                                    qty_d   = '0;
                                    state_d = ST_QTY;
                                end
                            end
                        endcase
                    end
                end
                ST_QTY: begin
                    if (ev_q.vld) begin
                        case (ev_q.kind)
                            EV_DIGIT: qty_d = ev_q.digit;
                            EV_BACK: begin
                                qty_d   = '0;
                                state_d = ST_SLOT;
                            end
                            default: begin
                                if (qty_q == 3'd0 || qty_q > cur_stock) begin
                                    err_d = 1'b1;
                                    qty_d = '0;
                                end else begin
                                    state_d     = ST_OFFER;
                                    sel_valid_d = 1'b1;
                                end
                            end
                        endcase
                    end
                end
                default: begin
                    // Handshake has priority over a simultaneous BACK.
                    if (sel_valid_q && sel_ready) begin
                        sel_valid_d = 1'b0;
                        slot_d      = '0;
                        qty_d       = '0;
                        state_d     = ST_IDLE;
                    end else if (ev_q.vld && ev_q.kind == EV_BACK) begin
                        sel_valid_d = 1'b0;
                        state_d     = ST_QTY;
                    end
                end
            endcase

            // Inactivity timer, only live while the user is mid-entry.
            if (state_q == ST_SLOT || state_q == ST_QTY) begin
                if (ev_q.vld || state_d != state_q) begin
                    idle_cnt_d = '0;
                end else if (idle_cnt_q == TIMEOUT_LAST) begin
                    idle_cnt_d = '0;
                    state_d    = ST_IDLE;
                    slot_d     = '0;
                    qty_d      = '0;
                end else begin
                    idle_cnt_d = idle_cnt_q + 1'b1;
                end
            end else begin
                idle_cnt_d = '0;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            settle_cnt_q <= '0;
            ev_q         <= '0;
            state_q      <= ST_IDLE;
            slot_q       <= '0;
            qty_q        <= '0;
            sel_valid_q  <= 1'b0;
            err_q        <= 1'b0;
            idle_cnt_q   <= '0;
        end else begin
            settle_cnt_q <= settle_cnt_d;
            ev_q         <= ev_d;
            state_q      <= state_d;
            slot_q       <= slot_d;
            qty_q        <= qty_d;
            sel_valid_q  <= sel_valid_d;
            err_q        <= err_d;
            idle_cnt_q   <= idle_cnt_d;
        end
    end

    assign sel_valid = sel_valid_q;
    assign sel_slot  = slot_q;
    assign sel_qty   = qty_q;
    assign err_pulse = err_q;
    assign ui_state  = state_q;

endmodule

// File: tb/tb_vend_select_fsm.sv
// tb_vend_select_fsm
//   Table of key presses with expected outputs, hand sequences for the
//   multi-cycle corners, and a randomized phase checked against a
//   press-level model of the selection rules.
module tb_vend_select_fsm;
    localparam int SETTLE  = 4;
    localparam int TIMEOUT = 200;
    localparam int K_DIG   = 0;
    localparam int K_OK    = 1;
    localparam int K_BACK  = 2;
    localparam int K_BOTH  = 3;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        key_valid = 1'b0;
    logic [2:0]  key_val = '0;
    logic        key_ok = 1'b0;
    logic        key_back = 1'b0;
    logic        admin_en = 1'b0;
    logic [20:0] stock_v = '0;
    logic        sel_ready = 1'b0;
    logic        sel_valid;
    logic [2:0]  sel_slot;
    logic [2:0]  sel_qty;
    logic        err_pulse;
    logic [1:0]  ui_state;

    int checks = 0;
    int errors = 0;
    int err_seen = 0;
    int valid_cyc = 0;
    int last_slot = 0;
    int last_qty = 0;

    int m_mode, m_slot, m_qty;

    vend_select_fsm #(.SETTLE_CYC(SETTLE), .TIMEOUT_CYC(TIMEOUT)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .key_valid(key_valid), .key_val(key_val), .key_ok(key_ok), .key_back(key_back),
        .admin_en(admin_en), .slot_stock(stock_v), .sel_ready(sel_ready),
        .sel_valid(sel_valid), .sel_slot(sel_slot), .sel_qty(sel_qty),
        .err_pulse(err_pulse), .ui_state(ui_state)
    );

    always #5 i_clk = ~i_clk;

    always @(negedge i_clk) begin
        if (err_pulse === 1'b1) err_seen++;
        if (sel_valid === 1'b1) begin
            valid_cyc++;
            last_slot = int'(sel_slot);
            last_qty  = int'(sel_qty);
        end
    end

    typedef struct {
        int kind;
        int d;
        int st;
        int slot;
        int qty;
        int err;
    } vec_t;

    vec_t tbl[19];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_out(input string tag, input int st, input int slot, input int qty);
        check({tag, ".state"}, 32'(ui_state), st);
        check({tag, ".slot"},  32'(sel_slot), slot);
        check({tag, ".qty"},   32'(sel_qty), qty);
        check({tag, ".valid"}, 32'(sel_valid), (st == 3) ? 1 : 0);
    endtask

    // Hold a key for 'hold' cycles, release, then let the result settle.
    task automatic drive_key(input int kind, input int d, input int hold);
        @(negedge i_clk);
        key_valid = 1'b1;
        key_val   = 3'(d);
        key_ok    = (kind == K_OK || kind == K_BOTH);
        key_back  = (kind == K_BACK || kind == K_BOTH);
        repeat (hold) @(negedge i_clk);
        key_valid = 1'b0;
        key_ok    = 1'b0;
        key_back  = 1'b0;
        key_val   = '0;
        repeat (3) @(negedge i_clk);
    endtask

    task automatic press(input int kind, input int d);
        drive_key(kind, d, SETTLE + 2);
    endtask

    function automatic int stock_of(input int n);
        return int'((stock_v >> (3 * (n - 1))) & 21'h7);
    endfunction

    // One accepted key press, at the level of the user-visible rules.
    task automatic model_press(input int kind_in, input int d, output int err);
        int kind;
        kind = (kind_in == K_BOTH) ? K_BACK : kind_in;
        err = 0;
        case (m_mode)
            0: if (kind == K_DIG && d != 0) begin m_slot = d; m_mode = 1; end
            1: begin
                if (kind == K_DIG) begin
                    if (d != 0) m_slot = d;
                end else if (kind == K_BACK) begin
                    m_slot = 0; m_mode = 0;
                end else if (stock_of(m_slot) == 0) begin
                    err = 1; m_slot = 0; m_mode = 0;
                end else begin
                    m_qty = 0; m_mode = 2;
                end
            end
            2: begin
                if (kind == K_DIG) m_qty = d;
                else if (kind == K_BACK) begin m_qty = 0; m_mode = 1; end
                else if (m_qty == 0 || m_qty > stock_of(m_slot)) begin err = 1; m_qty = 0; end
                else m_mode = 3;
            end
            default: if (kind == K_BACK) m_mode = 2;
        endcase
    endtask

    task automatic do_reset();
        @(negedge i_clk);
        i_rst_n = 1'b0;
        repeat (2) @(negedge i_clk);
        i_rst_n = 1'b1;
        @(negedge i_clk);
    endtask

    initial begin
        int e0, v0, merr, op, r, kind, d;

        tbl[0]  = '{K_DIG,  3, 1, 3, 0, 0};
        tbl[1]  = '{K_OK,   0, 2, 3, 0, 0};
        tbl[2]  = '{K_DIG,  2, 2, 3, 2, 0};
        tbl[3]  = '{K_BACK, 0, 1, 3, 0, 0};
        tbl[4]  = '{K_DIG,  5, 1, 5, 0, 0};
        tbl[5]  = '{K_OK,   0, 0, 0, 0, 1};
        tbl[6]  = '{K_DIG,  0, 0, 0, 0, 0};
        tbl[7]  = '{K_OK,   0, 0, 0, 0, 0};
        tbl[8]  = '{K_DIG,  1, 1, 1, 0, 0};
        tbl[9]  = '{K_DIG,  0, 1, 1, 0, 0};
        tbl[10] = '{K_OK,   0, 2, 1, 0, 0};
        tbl[11] = '{K_OK,   0, 2, 1, 0, 1};
        tbl[12] = '{K_DIG,  6, 2, 1, 6, 0};
        tbl[13] = '{K_OK,   0, 2, 1, 0, 1};
        tbl[14] = '{K_DIG,  4, 2, 1, 4, 0};
        tbl[15] = '{K_OK,   0, 3, 1, 4, 0};
        tbl[16] = '{K_DIG,  2, 3, 1, 4, 0};
        tbl[17] = '{K_BACK, 0, 2, 1, 4, 0};
        tbl[18] = '{K_OK,   0, 3, 1, 4, 0};

        // slot7..slot1 stock: 7,7,0,7,5,3,4
        stock_v = {3'd7, 3'd7, 3'd0, 3'd7, 3'd5, 3'd3, 3'd4};

        repeat (2) @(negedge i_clk);
        chk_out("reset", 0, 0, 0);
        check("reset.err", 32'(err_pulse), 0);
        i_rst_n = 1'b1;
        @(negedge i_clk);

        for (int i = 0; i < 19; i++) begin
            e0 = err_seen;
            press(tbl[i].kind, tbl[i].d);
            chk_out($sformatf("tbl%0d", i), tbl[i].st, tbl[i].slot, tbl[i].qty);
            check($sformatf("tbl%0d.err", i), err_seen - e0, tbl[i].err);
        end

        // Accept the pending offer (slot 1, qty 4).
        @(negedge i_clk);
        sel_ready = 1'b1;
        @(negedge i_clk);
        sel_ready = 1'b0;
        chk_out("accept", 0, 0, 0);

        // Full purchase with ready held high: valid lasts exactly one cycle.
        v0 = valid_cyc;
        sel_ready = 1'b1;
        press(K_DIG, 3); press(K_OK, 0); press(K_DIG, 2); press(K_OK, 0);
        sel_ready = 1'b0;
        check("buy.valid_cycles", valid_cyc - v0, 1);
        check("buy.slot", last_slot, 3);
        check("buy.qty", last_qty, 2);
        chk_out("buy.end", 0, 0, 0);

        // BACK out of OFFER, then BACK colliding with ready.
        press(K_DIG, 3); press(K_OK, 0); press(K_DIG, 2); press(K_OK, 0);
        chk_out("offer", 3, 3, 2);
        press(K_BACK, 0);
        chk_out("offer.back", 2, 3, 2);
        press(K_OK, 0);
        chk_out("reoffer", 3, 3, 2);
        @(negedge i_clk);
        key_valid = 1'b1;
        key_back  = 1'b1;
        repeat (SETTLE) @(negedge i_clk);
        sel_ready = 1'b1;
        @(negedge i_clk);
        sel_ready = 1'b0;
        chk_out("back_vs_ready", 0, 0, 0);
        key_valid = 1'b0;
        key_back  = 1'b0;
        repeat (4) @(negedge i_clk);
        chk_out("back_vs_ready.after", 0, 0, 0);

        // Long hold gives one event; short glitch gives none.
        e0 = err_seen;
        drive_key(K_DIG, 2, 50);
        chk_out("hold.digit", 1, 2, 0);
        drive_key(K_OK, 0, 50);
        chk_out("hold.ok", 2, 2, 0);
        check("hold.ok.err", err_seen - e0, 0);
        drive_key(K_BACK, 0, SETTLE - 1);
        chk_out("glitch", 2, 2, 0);
        drive_key(K_BACK, 0, SETTLE);
        chk_out("min_hold", 1, 2, 0);

        // Inactivity timeout in SLOT.
        e0 = err_seen;
        repeat (150) @(negedge i_clk);
        chk_out("timeout.before", 1, 2, 0);
        repeat (80) @(negedge i_clk);
        chk_out("timeout.after", 0, 0, 0);
        check("timeout.err", err_seen - e0, 0);

        // Admin clears an offer; keys masked while admin.
        press(K_DIG, 3); press(K_OK, 0); press(K_DIG, 2); press(K_OK, 0);
        chk_out("admin.offer", 3, 3, 2);
        @(negedge i_clk);
        admin_en = 1'b1;
        @(negedge i_clk);
        chk_out("admin.clear", 0, 0, 0);
        press(K_DIG, 4);
        chk_out("admin.masked", 0, 0, 0);
        admin_en = 1'b0;

        // Asynchronous reset mid-entry.
        press(K_DIG, 1);
        chk_out("pre_rst", 1, 1, 0);
        @(negedge i_clk);
        i_rst_n = 1'b0;
        #1;
        chk_out("async_rst", 0, 0, 0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        @(negedge i_clk);

        // Randomized phase against the press-level model.
        m_mode = 0; m_slot = 0; m_qty = 0;
        for (int i = 0; i < 80; i++) begin
            op = $urandom_range(0, 9);
            if (op < 2) begin
                @(negedge i_clk);
                sel_ready = 1'b1;
                @(negedge i_clk);
                sel_ready = 1'b0;
                @(negedge i_clk);
                if (m_mode == 3) begin m_mode = 0; m_slot = 0; m_qty = 0; end
                chk_out($sformatf("rnd%0d.acc", i), m_mode, m_slot, m_qty);
            end else begin
                if (op == 2) stock_v = 21'($urandom);
                r = $urandom_range(0, 19);
                kind = (r < 11) ? K_DIG : (r < 15) ? K_OK : (r < 18) ? K_BACK : K_BOTH;
                d = $urandom_range(0, 7);
                e0 = err_seen;
                press(kind, d);
                model_press(kind, d, merr);
                chk_out($sformatf("rnd%0d.k%0d", i, kind), m_mode, m_slot, m_qty);
                check($sformatf("rnd%0d.err", i), err_seen - e0, merr);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
